// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver clocked at 16x baud: two-flop synchroniser, 3-sample majority
// vote around mid-bit, and a single holding register with a vld_rx/rdy_rx handshake.
module uart_rx_os16 #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  input  logic                 rdy_rx,
  output logic                 vld_rx,
  output logic [DATA_BITS-1:0] d_rx,
  output logic                 frm_err,
  output logic                 ovr_err
);

  localparam int CW = $clog2(OSR);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_S0   = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OSR / 2);
  localparam logic [CW-1:0] CNT_EV   = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Handshake: a byte moves to the consumer on a rising clk edge where
  // vld_rx && rdy_rx; d_rx is stable whenever vld_rx is high.

  state_t                 state_q, state_d;
  logic                   s1_q, rxd_s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   samp0_q, samp0_d, samp1_q, samp1_d;
  logic                   vld_q, vld_d;
  logic [DATA_BITS-1:0]   dat_q, dat_d;
  logic                   frm_q, frm_d, ovr_q, ovr_d;
  logic                   maj, eval, deliver;

  assign maj  = (samp0_q & samp1_q) | (samp0_q & rxd_s_q) | (samp1_q & rxd_s_q);
  assign eval = (cnt_q == CNT_EV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    samp0_d = samp0_q;
    samp1_d = samp1_q;
    deliver = 1'b0;
    frm_d   = 1'b0;
    ovr_d   = 1'b0;
    vld_d   = vld_q;
    dat_d   = dat_q;

    if (state_q != IDLE) begin
      if (cnt_q == CNT_S0) samp0_d = rxd_s_q;
      if (cnt_q == CNT_S1) samp1_d = rxd_s_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = START;
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (eval && maj) begin
          // Start bit did not hold low through mid-bit: treat as a glitch.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (eval) begin
          shreg_d                = shreg_q >> 1;
          shreg_d[DATA_BITS-1]   = maj;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IW'(1);
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        // Leave at mid stop bit so the next start edge is caught early.
        if (eval) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (maj) deliver = 1'b1;
          else     frm_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (deliver) begin
      if (!vld_q) begin
        dat_d = shreg_q;
        vld_d = 1'b1;
      end else if (rdy_rx) begin
        dat_d = shreg_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && rdy_rx) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= 1'b1;
      rxd_s_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      samp0_q <= 1'b1;
      samp1_q <= 1'b1;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s1_q    <= rxd;
      rxd_s_q <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      samp0_q <= samp0_d;
      samp1_q <= samp1_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      frm_q   <= frm_d;
      ovr_q   <= ovr_d;
    end
  end

  assign vld_rx  = vld_q;
  assign d_rx    = dat_q;
  assign frm_err = frm_q;
  assign ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: frames bit-banged at 16 clk/bit, received
// bytes checked against an expected queue at each vld_rx && rdy_rx transfer.
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd;
  logic       rdy_rx;
  logic       vld_rx;
  logic [7:0] d_rx;
  logic       frm_err;
  logic       ovr_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int edge_cnt   = 0;
  int start_edge = 0;
  int last_rise  = 0;
  int rise_cnt   = 0;
  int frm_cnt    = 0;
  int frm_edge   = 0;
  int ovr_cnt    = 0;
  logic vld_prev = 1'b0;

  uart_rx_os16 dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rdy_rx  (rdy_rx),
    .vld_rx  (vld_rx),
    .d_rx    (d_rx),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor + scoreboard, sampled mid-low-phase
  always @(negedge clk) begin
    #2;
    if (vld_rx === 1'b1 && vld_prev !== 1'b1) begin
      rise_cnt  = rise_cnt + 1;
      last_rise = edge_cnt;
    end
    vld_prev = vld_rx;
    if (frm_err === 1'b1) begin
      frm_cnt  = frm_cnt + 1;
      frm_edge = edge_cnt;
    end
    if (ovr_err === 1'b1) ovr_cnt = ovr_cnt + 1;
    if (vld_rx === 1'b1 && rdy_rx === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $error("FAIL sb_unexpected: observed %0h expected none", d_rx);
      end else begin
        check("sb_byte", {24'h0, d_rx}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // drivers: called at a negedge, return at a negedge with the line idle
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch);
    start_edge = edge_cnt;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) begin
        rxd = (glitch && k == 9) ? ~b[i] : b[i];
        @(negedge clk);
      end
    end
    rxd = stop_v;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r0, f0, o0, fs;
    rstn   = 1'b0;
    rxd    = 1'b1;
    rdy_rx = 1'b0;
    idle(3);
    check("rst_vld", {31'h0, vld_rx}, 32'h0);
    check("rst_d", {24'h0, d_rx}, 32'h0);
    check("rst_frm", {31'h0, frm_err}, 32'h0);
    check("rst_ovr", {31'h0, ovr_err}, 32'h0);
    rstn = 1'b1;
    idle(5);

    // 0xA5 with rdy low: latency, data, then one-cycle consume
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(4);
    check("a5_rise", rise_cnt, r0 + 1);
    check("a5_latency", last_rise - start_edge, 157);
    check("a5_d", {24'h0, d_rx}, 32'hA5);
    check("a5_vld", {31'h0, vld_rx}, 32'h1);
    check("a5_frm", frm_cnt, 0);
    check("a5_ovr", ovr_cnt, 0);
    exp_q.push_back(8'hA5);
    rdy_rx = 1'b1;
    @(negedge clk);
    rdy_rx = 1'b0;
    #3;
    check("a5_consumed", {31'h0, vld_rx}, 32'h0);
    @(negedge clk);

    // 4-cycle low glitch is rejected
    r0 = rise_cnt; f0 = frm_cnt; o0 = ovr_cnt;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(200);
    check("glitch_rise", rise_cnt, r0);
    check("glitch_frm", frm_cnt, f0);
    check("glitch_ovr", ovr_cnt, o0);

    // framing error on 0x3C, then a good 0x55
    r0 = rise_cnt; f0 = frm_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    fs = start_edge;
    idle(32);
    check("frm_pulse", frm_cnt, f0 + 1);
    check("frm_edge", frm_edge - fs, 157);
    check("frm_no_vld", rise_cnt, r0);
    rdy_rx = 1'b1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(4);
    check("after_frm_rise", rise_cnt, r0 + 1);
    rdy_rx = 1'b0;
    idle(2);

    // back-to-back with rdy low: overrun, first byte kept
    r0 = rise_cnt; o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(4);
    check("ovr_pulse", ovr_cnt, o0 + 1);
    check("ovr_d", {24'h0, d_rx}, 32'h11);
    check("ovr_rise", rise_cnt, r0 + 1);
    exp_q.push_back(8'h11);
    rdy_rx = 1'b1;
    @(negedge clk);
    rdy_rx = 1'b0;
    idle(2);

    // back-to-back with rdy high: both delivered
    r0 = rise_cnt; o0 = ovr_cnt;
    rdy_rx = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(4);
    check("b2b_rise", rise_cnt, r0 + 2);
    check("b2b_ovr", ovr_cnt, o0);

    // single-cycle glitch at mid-bit of every data bit is voted out
    r0 = rise_cnt;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(4);
    check("vote_rise", rise_cnt, r0 + 1);
    rdy_rx = 1'b0;
    idle(2);

    // reset mid-DATA of 0xF0 while a byte is held
    send_frame(8'h99, 1'b1, 1'b0);
    idle(4);
    check("pre_rst_vld", {31'h0, vld_rx}, 32'h1);
    rxd = 1'b0;
    idle(16 + 48 + 8);
    rstn = 1'b0;
    #1;
    check("midrst_vld", {31'h0, vld_rx}, 32'h0);
    check("midrst_d", {24'h0, d_rx}, 32'h0);
    check("midrst_frm", {31'h0, frm_err}, 32'h0);
    check("midrst_ovr", {31'h0, ovr_err}, 32'h0);
    rxd = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(20);
    r0 = rise_cnt; f0 = frm_cnt; o0 = ovr_cnt;
    rdy_rx = 1'b1;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(4);
    check("post_rst_rise", rise_cnt, r0 + 1);
    check("post_rst_frm", frm_cnt, f0);
    check("post_rst_ovr", ovr_cnt, o0);
    rdy_rx = 1'b0;
    idle(4);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
